// File: rtl/cdp1802_dma_responder.sv
`default_nettype none
// ============================================================================
// Module   : cdp1802_dma_responder
// Purpose  : CPU-side responder for the CDP1861 video DMA / interrupt
//            handshake. Generates the 1802 machine-cycle timing (TPA, TPB,
//            SC), arbitrates DMA-out and interrupt requests against CPU
//            cycles, performs each DMA-out fetch from RAM at R0 with R0
//            post-increment, and stalls the CPU core for every cycle it owns.
// Config   : define DMA_INT_ACK_EN to enable interrupt-acknowledge cycles.
//            Without it only CPU and DMA cycles exist and int_ack is tied 0.
// Ports    : clock, Reset_ (async, active low), cycle_ce (1802 clock enable)
//            dmao, int_req, ie            - request / enable inputs
//            r0_load, r0_din              - R0 load interface
//            ram_addr, ram_rd, ram_dout   - RAM read port (1-clock latency)
//            data_out                     - DMA byte to CDP1861 DataIn
//            tpa, tpb, sc, cpu_stall      - machine-cycle timing / status
//            int_ack                      - interrupt cycle completion pulse
//            r0                           - current R0
// Revision : 1.0 - initial release
// ============================================================================
module cdp1802_dma_responder #(
  parameter int CYCLE_LEN = 8,
  parameter int TPA_POS   = 1,
  parameter int TPB_POS   = 6
) (
  input  logic        clock,
  input  logic        Reset_,
  input  logic        cycle_ce,
  input  logic        dmao,
  input  logic        int_req,
  input  logic        ie,
  input  logic        r0_load,
  input  logic [15:0] r0_din,
  output logic [15:0] ram_addr,
  output logic        ram_rd,
  input  logic [7:0]  ram_dout,
  output logic [7:0]  data_out,
  output logic        tpa,
  output logic        tpb,
  output logic [1:0]  sc,
  output logic        cpu_stall,
  output logic        int_ack,
  output logic [15:0] r0
);

  localparam logic [2:0] LAST_CNT  = 3'(CYCLE_LEN - 1);
  localparam logic [2:0] TPA_CNT   = 3'(TPA_POS);
  localparam logic [2:0] TPB_CNT   = 3'(TPB_POS);
  localparam logic [2:0] RD_CNT    = 3'd2;
  localparam logic [2:0] LATCH_CNT = 3'd3;

  // State encoding doubles as the SC code driven to the bus.
  typedef enum logic [1:0] {
    ST_CPU = 2'b01,
    ST_DMA = 2'b10,
    ST_INT = 2'b11
  } cyc_e;

  logic [2:0]  count_q, count_d;
  cyc_e        type_q, type_d;
  cyc_e        next_type;
  logic [15:0] r0_q, r0_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        tpa_q, tpa_d;
  logic        tpb_q, tpb_d;
  logic        ram_rd_q, ram_rd_d;
  logic        stall_q, stall_d;
`ifdef DMA_INT_ACK_EN
  logic        int_ack_q, int_ack_d;
`endif

  // Arbitration for the cycle that follows the current count-7 sample.
  // DMA always wins; interrupts only when enabled in this build.
  always_comb begin
    next_type = ST_CPU;
    if (dmao) begin
      next_type = ST_DMA;
    end
`ifdef DMA_INT_ACK_EN
    else if (int_req && ie) begin
      next_type = ST_INT;
    end
`endif
  end

  // Timing outputs are computed from the next count/type so that the
  // registered copies line up exactly with the count they describe.
  always_comb begin
    count_d    = count_q;
    type_d     = type_q;
    r0_d       = r0_q;
    data_out_d = data_out_q;
    tpa_d      = tpa_q;
    tpb_d      = tpb_q;
    ram_rd_d   = ram_rd_q;
    stall_d    = stall_q;
`ifdef DMA_INT_ACK_EN
    int_ack_d  = int_ack_q;
`endif
    if (cycle_ce) begin
      if (count_q == LAST_CNT) begin
        count_d = 3'd0;
        type_d  = next_type;
      end else begin
        count_d = count_q + 3'd1;
      end

      tpa_d    = (count_d == TPA_CNT);
      tpb_d    = (count_d == TPB_CNT);
      ram_rd_d = (type_d == ST_DMA) && (count_d == RD_CNT);
      stall_d  = (type_d != ST_CPU);
`ifdef DMA_INT_ACK_EN
      int_ack_d = (type_d == ST_INT) && (count_d == LAST_CNT);
`endif

      // RAM answers one clock after the count-2 read strobe.
      if (type_q == ST_DMA && count_q == LATCH_CNT) begin
        data_out_d = ram_dout;
      end

      // An explicit load overrides the end-of-DMA post-increment.
      if (r0_load) begin
        r0_d = r0_din;
      end else if (type_q == ST_DMA && count_q == LAST_CNT) begin
        r0_d = r0_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge Reset_) begin
    if (!Reset_) begin
      count_q    <= 3'd0;
      type_q     <= ST_CPU;
      r0_q       <= 16'h0000;
      data_out_q <= 8'h00;
      tpa_q      <= 1'b0;
      tpb_q      <= 1'b0;
      ram_rd_q   <= 1'b0;
      stall_q    <= 1'b0;
`ifdef DMA_INT_ACK_EN
      int_ack_q  <= 1'b0;
`endif
    end else begin
      count_q    <= count_d;
      type_q     <= type_d;
      r0_q       <= r0_d;
      data_out_q <= data_out_d;
      tpa_q      <= tpa_d;
      tpb_q      <= tpb_d;
      ram_rd_q   <= ram_rd_d;
      stall_q    <= stall_d;
`ifdef DMA_INT_ACK_EN
      int_ack_q  <= int_ack_d;
`endif
    end
  end

  assign r0        = r0_q;
  assign ram_addr  = r0_q;
  assign ram_rd    = ram_rd_q;
  assign data_out  = data_out_q;
  assign tpa       = tpa_q;
  assign tpb       = tpb_q;
  assign sc        = type_q;
  assign cpu_stall = stall_q;

`ifdef DMA_INT_ACK_EN
  assign int_ack = int_ack_q;
`else
  // Interrupt inputs have no function in a DMA-only build.
  logic unused_int_in;
  assign unused_int_in = int_req ^ ie;
  assign int_ack       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdp1802_dma_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdp1802_dma_responder
// Purpose  : Directed self-checking bench for cdp1802_dma_responder. The bench
//            tracks the machine-cycle count itself and checks timing pulses,
//            DMA fetches, arbitration, R0 wrap/load priority and async reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdp1802_dma_responder;

  logic        clock = 1'b0;
  logic        Reset_;
  logic        cycle_ce;
  logic        dmao;
  logic        int_req;
  logic        ie;
  logic        r0_load;
  logic [15:0] r0_din;
  logic [15:0] ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_dout = 8'h00;
  logic [7:0]  data_out;
  logic        tpa;
  logic        tpb;
  logic [1:0]  sc;
  logic        cpu_stall;
  logic        int_ack;
  logic [15:0] r0;

  int          total  = 0;
  int          passed = 0;
  logic [2:0]  cnt    = 3'd0;   // bench's own model of the machine-cycle count

  logic [7:0]  mem [0:65535];

  cdp1802_dma_responder dut (
    .clock     (clock),
    .Reset_    (Reset_),
    .cycle_ce  (cycle_ce),
    .dmao      (dmao),
    .int_req   (int_req),
    .ie        (ie),
    .r0_load   (r0_load),
    .r0_din    (r0_din),
    .ram_addr  (ram_addr),
    .ram_rd    (ram_rd),
    .ram_dout  (ram_dout),
    .data_out  (data_out),
    .tpa       (tpa),
    .tpb       (tpb),
    .sc        (sc),
    .cpu_stall (cpu_stall),
    .int_ack   (int_ack),
    .r0        (r0)
  );

  always #5 clock = ~clock;

  // Synchronous RAM with one clock of read latency.
  always @(posedge clock) begin
    if (ram_rd) ram_dout <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clock);
    #1;
    if (cycle_ce && Reset_) cnt = cnt + 3'd1;
  endtask

  task automatic run_to(input logic [2:0] c);
    while (cnt != c) tick();
  endtask

  task automatic load_r0(input logic [15:0] v);
    r0_load = 1'b1;
    r0_din  = v;
    tick();
    r0_load = 1'b0;
    total++; if (r0 !== v) $display("FAIL load_r0: r0 got %h exp %h", r0, v); else passed++;
  endtask

  // Runs one DMA machine cycle; entered with cnt==7 and dmao high, leaves
  // with cnt==7 of the DMA cycle (R0 not yet incremented).
  task automatic dma_cycle(input logic [15:0] a, input logic [7:0] d, input bit drop);
    for (int k = 0; k < 8; k++) begin
      tick();
      case (cnt)
        3'd0: begin
          total++; if (sc !== 2'b10) $display("FAIL dma_sc: got %b exp 10", sc); else passed++;
          total++; if (cpu_stall !== 1'b1) $display("FAIL dma_stall: got %b exp 1", cpu_stall); else passed++;
        end
        3'd1: begin
          total++; if (tpa !== 1'b1) $display("FAIL dma_tpa: got %b exp 1", tpa); else passed++;
        end
        3'd2: begin
          total++; if (ram_rd !== 1'b1) $display("FAIL dma_rd: got %b exp 1", ram_rd); else passed++;
          total++; if (ram_addr !== a) $display("FAIL dma_addr: got %h exp %h", ram_addr, a); else passed++;
        end
        3'd3: begin
          total++; if (ram_rd !== 1'b0) $display("FAIL dma_rd_width: got %b exp 0", ram_rd); else passed++;
          if (drop) dmao = 1'b0;
        end
        3'd4: begin
          total++; if (data_out !== d) $display("FAIL dma_data: got %h exp %h", data_out, d); else passed++;
        end
        3'd6: begin
          total++; if (tpb !== 1'b1) $display("FAIL dma_tpb: got %b exp 1", tpb); else passed++;
        end
        3'd7: begin
          total++; if (r0 !== a) $display("FAIL dma_r0_hold: got %h exp %h", r0, a); else passed++;
          total++; if (int_ack !== 1'b0) $display("FAIL dma_int_ack: got %b exp 0", int_ack); else passed++;
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    Reset_ = 1'b0; cycle_ce = 1'b1; dmao = 1'b0; int_req = 1'b0; ie = 1'b0;
    r0_load = 1'b0; r0_din = 16'h0000;
    repeat (3) tick();
    total++; if (sc !== 2'b01) $display("FAIL rst_sc: got %b exp 01", sc); else passed++;
    total++; if (r0 !== 16'h0000) $display("FAIL rst_r0: got %h exp 0000", r0); else passed++;
    total++; if (ram_addr !== 16'h0000) $display("FAIL rst_addr: got %h exp 0000", ram_addr); else passed++;
    total++; if (data_out !== 8'h00) $display("FAIL rst_data: got %h exp 00", data_out); else passed++;
    total++; if ({tpa, tpb, ram_rd, int_ack, cpu_stall} !== 5'b0)
      $display("FAIL rst_strobes: got %b exp 00000", {tpa, tpb, ram_rd, int_ack, cpu_stall}); else passed++;
    Reset_ = 1'b1;
    cnt    = 3'd0;
    for (int k = 0; k < 16; k++) begin
      tick();
      total++; if (tpa !== (cnt == 3'd1)) $display("FAIL tpa_pos: cnt %0d got %b exp %b", cnt, tpa, cnt == 3'd1); else passed++;
      total++; if (tpb !== (cnt == 3'd6)) $display("FAIL tpb_pos: cnt %0d got %b exp %b", cnt, tpb, cnt == 3'd6); else passed++;
      total++; if ({sc, cpu_stall} !== 3'b010) $display("FAIL cpu_cycle: got sc %b stall %b exp 01/0", sc, cpu_stall); else passed++;
    end
  endtask

  task automatic test_ce_hold();
    run_to(3'd1);
    cycle_ce = 1'b0;
    repeat (3) begin
      tick();
      total++; if (tpa !== 1'b1) $display("FAIL ce_hold_tpa: got %b exp 1", tpa); else passed++;
    end
    cycle_ce = 1'b1;
    tick();
    total++; if (tpa !== 1'b0) $display("FAIL ce_resume_tpa: got %b exp 0", tpa); else passed++;
  endtask

  task automatic test_dma_burst();
    load_r0(16'h0100);
    dmao = 1'b1;
    run_to(3'd7);
    for (int i = 0; i < 8; i++) dma_cycle(16'h0100 + 16'(i), 8'h10 + 8'(i), i == 7);
    tick();
    total++; if (r0 !== 16'h0108) $display("FAIL burst_r0: got %h exp 0108", r0); else passed++;
    total++; if (sc !== 2'b01) $display("FAIL burst_end_sc: got %b exp 01", sc); else passed++;
    total++; if (data_out !== 8'h17) $display("FAIL burst_data_hold: got %h exp 17", data_out); else passed++;
  endtask

  task automatic test_int_priority();
    load_r0(16'h0400);
    dmao = 1'b1; int_req = 1'b1; ie = 1'b1;
    run_to(3'd7);
    dma_cycle(16'h0400, 8'h40, 1'b0);
    dma_cycle(16'h0401, 8'h41, 1'b1);
    for (int k = 0; k < 8; k++) begin
      tick();
`ifdef DMA_INT_ACK_EN
      total++; if (sc !== 2'b11) $display("FAIL int_sc: got %b exp 11", sc); else passed++;
      total++; if (cpu_stall !== 1'b1) $display("FAIL int_stall: got %b exp 1", cpu_stall); else passed++;
      total++; if (int_ack !== (cnt == 3'd7)) $display("FAIL int_ack: cnt %0d got %b", cnt, int_ack); else passed++;
      if (cnt == 3'd3) begin ie = 1'b0; int_req = 1'b0; end
`else
      total++; if (sc !== 2'b01) $display("FAIL noint_sc: got %b exp 01", sc); else passed++;
      total++; if (int_ack !== 1'b0) $display("FAIL noint_ack: got %b exp 0", int_ack); else passed++;
`endif
      total++; if (ram_rd !== 1'b0) $display("FAIL int_no_rd: got %b exp 0", ram_rd); else passed++;
    end
    ie = 1'b0; int_req = 1'b0;
    tick();
    total++; if (sc !== 2'b01) $display("FAIL post_int_sc: got %b exp 01", sc); else passed++;
    total++; if (int_ack !== 1'b0) $display("FAIL post_int_ack: got %b exp 0", int_ack); else passed++;
    total++; if (r0 !== 16'h0402) $display("FAIL post_int_r0: got %h exp 0402", r0); else passed++;
  endtask

  task automatic test_r0_wrap();
    load_r0(16'hFFFF);
    dmao = 1'b1;
    run_to(3'd7);
    dma_cycle(16'hFFFF, 8'hEE, 1'b1);
    tick();
    total++; if (r0 !== 16'h0000) $display("FAIL wrap_r0: got %h exp 0000", r0); else passed++;
    total++; if (ram_addr !== 16'h0000) $display("FAIL wrap_addr: got %h exp 0000", ram_addr); else passed++;
  endtask

  task automatic test_load_priority();
    load_r0(16'h0150);
    dmao = 1'b1;
    run_to(3'd7);
    dma_cycle(16'h0150, 8'h55, 1'b1);
    r0_load = 1'b1;
    r0_din  = 16'h0200;
    tick();
    r0_load = 1'b0;
    total++; if (r0 !== 16'h0200) $display("FAIL load_prio_r0: got %h exp 0200", r0); else passed++;
    tick();
    total++; if (r0 !== 16'h0200) $display("FAIL load_prio_hold: got %h exp 0200", r0); else passed++;
  endtask

  task automatic test_reset_mid_dma();
    load_r0(16'h0300);
    dmao = 1'b1;
    run_to(3'd7);
    tick();
    dmao = 1'b0;
    run_to(3'd4);
    total++; if (data_out !== 8'hA5) $display("FAIL pre_rst_data: got %h exp a5", data_out); else passed++;
    Reset_ = 1'b0;
    #1;
    total++; if (r0 !== 16'h0000) $display("FAIL mid_rst_r0: got %h exp 0000", r0); else passed++;
    total++; if (sc !== 2'b01) $display("FAIL mid_rst_sc: got %b exp 01", sc); else passed++;
    total++; if (data_out !== 8'h00) $display("FAIL mid_rst_data: got %h exp 00", data_out); else passed++;
    total++; if (cpu_stall !== 1'b0) $display("FAIL mid_rst_stall: got %b exp 0", cpu_stall); else passed++;
    tick();
    tick();
    Reset_ = 1'b1;
    cnt    = 3'd0;
    load_r0(16'h0300);
    dmao = 1'b1;
    run_to(3'd7);
    dma_cycle(16'h0300, 8'hA5, 1'b1);
    tick();
    total++; if (r0 !== 16'h0301) $display("FAIL post_rst_r0: got %h exp 0301", r0); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[16'h0100 + 16'(i)] = 8'h10 + 8'(i);
    mem[16'h0400] = 8'h40;
    mem[16'h0401] = 8'h41;
    mem[16'hFFFF] = 8'hEE;
    mem[16'h0150] = 8'h55;
    mem[16'h0300] = 8'hA5;

    test_reset();
    test_ce_hold();
    test_dma_burst();
    test_int_priority();
    test_r0_wrap();
    test_load_priority();
    test_reset_mid_dma();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
